// File: rtl/custom_bus_regfile_if.sv
// Chip-select register bus between the decoder and a register file.
// Master drives requests; slave returns registered read responses.
interface custom_bus_regfile_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
);
  localparam int SW = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr;
  logic                  chip_select;
  logic                  write_en;
  logic                  read_en;
  logic [DATA_WIDTH-1:0] write_data;
  logic [SW-1:0]         write_strb;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  data_valid;
  logic                  resp_err;

  modport master (
    output addr, chip_select, write_en, read_en,
    output write_data, write_strb,
    input  read_data, data_valid, resp_err
  );

  modport slave (
    input  addr, chip_select, write_en, read_en,
    input  write_data, write_strb,
    output read_data, data_valid, resp_err
  );
endinterface

// File: rtl/custom_bus_regfile.sv
// Register file with RW/RO/W1P/W1C/RC access types, byte strobes,
// registered read path, error response and interrupt summary.
module custom_bus_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int NUM_REGS   = 4,
  parameter logic [3*NUM_REGS-1:0] REG_TYPES =
    {NUM_REGS{3'd0}},
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  custom_bus_regfile_if.slave            bus,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_in,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
  output logic [NUM_REGS*DATA_WIDTH-1:0] pulse_out,
  output logic                           irq
);

  localparam int DW  = DATA_WIDTH;
  localparam int SW  = DW / 8;
  localparam int OFF = $clog2(SW);

  localparam logic [2:0] T_RW  = 3'd0;
  localparam logic [2:0] T_W1P = 3'd2;
  localparam logic [2:0] T_W1C = 3'd3;
  localparam logic [2:0] T_RC  = 3'd4;

  localparam logic [ADDR_WIDTH-1:0] AMASK =
    ADDR_WIDTH'(SW - 1);
  localparam logic [ADDR_WIDTH:0] NREG =
    (ADDR_WIDTH+1)'(NUM_REGS);

  logic [ADDR_WIDTH-1:0] idx;
  logic                  misaligned;
  logic                  addr_ok;
  logic                  both_en;
  logic                  write_act;
  logic                  read_act;
  logic                  wr_ok;
  logic                  rd_ok;
  logic                  err;
  logic [DW-1:0]         bmask;
  logic [DW-1:0]         rval;

  logic [NUM_REGS-1:0][DW-1:0] rd_arr;
  logic [NUM_REGS-1:0]         irq_v;

  assign idx        = bus.addr >> OFF;
  assign misaligned = |(bus.addr & AMASK);
  assign addr_ok    = ~misaligned & ({1'b0, idx} < NREG);

  assign both_en   = bus.chip_select & bus.write_en
                   & bus.read_en;
  assign write_act = bus.chip_select & bus.write_en
                   & ~bus.read_en;
  assign read_act  = bus.chip_select & bus.read_en
                   & ~bus.write_en;

  assign wr_ok = write_act & addr_ok;
  assign rd_ok = read_act & addr_ok;
  assign err   = both_en
               | ((write_act | read_act) & ~addr_ok);

  // Expand byte strobes into a bit mask.
  always_comb begin
    bmask = '0;
    for (int b = 0; b < SW; b++)
      bmask[8*b +: 8] = {8{bus.write_strb[b]}};
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    localparam logic [2:0] T = REG_TYPES[3*i +: 3];
    localparam bit IS_RW  = (T == T_RW);
    localparam bit IS_W1P = (T == T_W1P);
    localparam bit IS_W1C = (T == T_W1C);
    localparam bit IS_RC  = (T == T_RC);
    localparam bit IS_ST  = IS_RW | IS_W1C | IS_RC;
    localparam logic [DW-1:0] RV =
      IS_ST ? RESET_VALUES[i*DW +: DW] : '0;

    logic [DW-1:0] st;
    logic [DW-1:0] nxt;
    logic [DW-1:0] pls;
    logic [DW-1:0] pls_q;
    logic [DW-1:0] hw;
    logic [DW-1:0] rv;
    logic [DW-1:0] wmask;
    logic          wsel;
    logic          rsel;

    assign hw    = hw_in[i*DW +: DW];
    assign wsel  = wr_ok & (idx == ADDR_WIDTH'(i));
    assign rsel  = rd_ok & (idx == ADDR_WIDTH'(i));
    assign wmask = bus.write_data & bmask;

    // Per-type next storage, pulse and read value.
    always_comb begin
      nxt = st;
      pls = '0;
      rv  = st;
      unique case (1'b1)
        IS_RW: begin
          if (wsel)
            nxt = (st & ~bmask) | wmask;
        end
        IS_W1P: begin
          nxt = '0;
          rv  = '0;
          if (wsel)
            pls = wmask;
        end
        IS_W1C: begin
          nxt = (st & ~(wsel ? wmask : '0)) | hw;
        end
        IS_RC: begin
          nxt = (rsel ? '0 : st) | hw;
        end
        default: begin
          nxt = st;
          rv  = hw;
        end
      endcase
    end

    // Storage and one-cycle write pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st    <= RV;
        pls_q <= '0;
      end else begin
        st    <= nxt;
        pls_q <= pls;
      end
    end

    assign reg_out[i*DW +: DW]   = rv;
    assign pulse_out[i*DW +: DW] = pls_q;
    assign rd_arr[i]             = rv;
    assign irq_v[i] = (IS_W1C | IS_RC) & (|st);
  end

  assign irq = |irq_v;

  // Select the addressed register's read value.
  always_comb begin
    rval = '0;
    for (int k = 0; k < NUM_REGS; k++)
      if (idx == ADDR_WIDTH'(k))
        rval = rd_arr[k];
  end

  // Registered read response and error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.read_data  <= '0;
      bus.data_valid <= 1'b0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.data_valid <= rd_ok | err;
      bus.resp_err   <= err;
      if (rd_ok)
        bus.read_data <= rval;
      else if (err)
        bus.read_data <= '0;
    end
  end

endmodule

// File: tb/tb_custom_bus_regfile.sv
// Scoreboard bench for custom_bus_regfile: directed accesses,
// queued expected responses checked by an independent monitor.
module tb_custom_bus_regfile;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int NR = 5;
  localparam logic [3*NR-1:0] TYPES =
    {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
  localparam logic [NR*DW-1:0] RSTV =
    {{(NR-1)*DW{1'b0}}, 32'hA5A5_0000};

  typedef struct packed {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  logic clk;
  logic rst_n;
  logic [NR*DW-1:0] hw_in;
  logic [NR*DW-1:0] reg_out;
  logic [NR*DW-1:0] pulse_out;
  logic irq;

  int vectors;
  int fails;
  exp_t q[$];
  exp_t got;

  custom_bus_regfile_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus();

  custom_bus_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(NR),
    .REG_TYPES(TYPES), .RESET_VALUES(RSTV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus),
    .hw_in(hw_in), .reg_out(reg_out),
    .pulse_out(pulse_out), .irq(irq)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  always @(posedge clk) begin
    #1;
    if (bus.data_valid) begin
      vectors++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL spurious_valid got d=%h e=%b want none",
                 bus.read_data, bus.resp_err);
      end else begin
        got = q.pop_front();
        if (bus.read_data !== got.d || bus.resp_err !== got.e) begin
          fails++;
          $display("FAIL resp got d=%h e=%b want d=%h e=%b",
                   bus.read_data, bus.resp_err, got.d, got.e);
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    bus.chip_select = 0;
    bus.write_en    = 0;
    bus.read_en     = 0;
    bus.addr        = '0;
    bus.write_data  = '0;
    bus.write_strb  = '0;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic [3:0] s);
    bus.chip_select = 1;
    bus.write_en    = 1;
    bus.read_en     = 0;
    bus.addr        = a;
    bus.write_data  = d;
    bus.write_strb  = s;
    step();
    idle();
  endtask

  task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] d,
                    input logic e);
    q.push_back('{d: d, e: e});
    bus.chip_select = 1;
    bus.write_en    = 0;
    bus.read_en     = 1;
    bus.addr        = a;
    step();
    idle();
  endtask

  task automatic set_hw(input int i, input logic [DW-1:0] v);
    hw_in[i*DW +: DW] = v;
  endtask

  function automatic logic [DW-1:0] ro(input int i);
    return reg_out[i*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] po(input int i);
    return pulse_out[i*DW +: DW];
  endfunction

  initial begin
    vectors = 0;
    fails   = 0;
    rst_n   = 0;
    hw_in   = '0;
    idle();
    step();
    step();
    chk("rst_reg0", ro(0), 32'hA5A5_0000);
    chk("rst_rdata", bus.read_data, '0);
    chk("rst_valid", {31'd0, bus.data_valid}, '0);
    chk("rst_irq", {31'd0, irq}, '0);
    chk("rst_pulse2", po(2), '0);
    rst_n = 1;
    step();

    wr(8'h00, 32'h1234_5678, 4'b0101);
    chk("rw_reg0", ro(0), 32'hA534_0078);
    chk("rw_novalid", {31'd0, bus.data_valid}, '0);
    rd(8'h00, 32'hA534_0078, 0);

    set_hw(1, 32'hDEAD_BEEF);
    wr(8'h04, 32'h0000_0000, 4'b1111);
    chk("ro_regout", ro(1), 32'hDEAD_BEEF);
    rd(8'h04, 32'hDEAD_BEEF, 0);
    step();
    chk("rdata_hold", bus.read_data, 32'hDEAD_BEEF);

    wr(8'h08, 32'h0000_0011, 4'b1111);
    chk("w1p_pulse", po(2), 32'h11);
    step();
    chk("w1p_gone", po(2), '0);
    rd(8'h08, 32'h0, 0);

    set_hw(3, 32'h10);
    step();
    set_hw(3, 32'h0);
    chk("w1c_irq_up", {31'd0, irq}, 32'd1);
    chk("w1c_set", ro(3), 32'h10);
    set_hw(3, 32'h10);
    wr(8'h0C, 32'h10, 4'b1111);
    set_hw(3, 32'h0);
    chk("w1c_setwins", ro(3), 32'h10);
    wr(8'h0C, 32'h10, 4'b1111);
    chk("w1c_clr", ro(3), '0);
    chk("w1c_irq_dn", {31'd0, irq}, '0);

    set_hw(4, 32'h3);
    step();
    set_hw(4, 32'h0);
    chk("rc_irq_up", {31'd0, irq}, 32'd1);
    rd(8'h10, 32'h3, 0);
    rd(8'h10, 32'h0, 0);
    chk("rc_cleared", ro(4), '0);
    chk("rc_irq_dn", {31'd0, irq}, '0);

    rd(8'h02, 32'h0, 1);
    q.push_back('{d: '0, e: 1'b1});
    wr(8'h14, 32'hFFFF_FFFF, 4'b1111);
    rd(8'h14, 32'h0, 1);
    q.push_back('{d: '0, e: 1'b1});
    bus.chip_select = 1;
    bus.write_en    = 1;
    bus.read_en     = 1;
    bus.addr        = 8'h00;
    bus.write_data  = 32'hFFFF_FFFF;
    bus.write_strb  = 4'hF;
    step();
    idle();
    chk("err_nochg0", ro(0), 32'hA534_0078);
    chk("err_nochg3", ro(3), '0);

    q.push_back('{d: 32'hA534_0078, e: 1'b0});
    q.push_back('{d: 32'hDEAD_BEEF, e: 1'b0});
    bus.chip_select = 1;
    bus.read_en     = 1;
    bus.addr        = 8'h00;
    step();
    bus.addr        = 8'h04;
    step();
    idle();
    step();

    bus.chip_select = 1;
    bus.write_en    = 1;
    bus.addr        = 8'h00;
    bus.write_data  = 32'h0;
    bus.write_strb  = 4'hF;
    #3;
    rst_n = 0;
    step();
    idle();
    step();
    rst_n = 1;
    step();
    chk("mid_rst_reg0", ro(0), 32'hA5A5_0000);
    chk("mid_rst_rdata", bus.read_data, '0);
    step();
    step();
    chk("queue_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, fails);
    $finish;
  end

endmodule

// File: doc/custom_bus_regfile.md
# custom_bus_regfile

Parametrised register file on the custom chip-select bus (addr / chip_select / write_en / read_en). Each register has a per-register access type: read-write, hardware read-only, write-1-pulse, write-1-clear sticky, or read-clear. It adds byte strobes, a registered read path with a one-cycle `data_valid`, error response and an interrupt summary. The block sits between the bus decoder and the peripheral's control/status logic.

## Interface
- `DATA_WIDTH`, 32: register and bus data width; must be a multiple of 8.
- `ADDR_WIDTH`, 8: byte address width.
- `NUM_REGS`, 4: number of registers, 1..2^ADDR_WIDTH/(DATA_WIDTH/8).
- `REG_TYPES`, {NUM_REGS{3'd0}}: packed 3 bits per register, reg i at [3i+2:3i]. 0 = RW, 1 = RO, 2 = W1P, 3 = W1C, 4 = RC; 5-7 behave as RO.
- `RESET_VALUES`, 0: packed DATA_WIDTH bits per register; reset value of RW/W1C/RC storage.
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `addr`  in  ADDR_WIDTH  byte address; reg i at i*(DATA_WIDTH/8).
- `chip_select`  in  1  bus select.
- `write_en`  in  1  write request, qualified by chip_select.
- `read_en`  in  1  read request, qualified by chip_select.
- `write_data`  in  DATA_WIDTH  write data.
- `write_strb`  in  DATA_WIDTH/8  byte enables for writes.
- `read_data`  out  DATA_WIDTH  registered read data.
- `data_valid`  out  1  one-cycle pulse; read_data/resp_err valid.
- `resp_err`  out  1  error flag for the access completing this cycle.
- `hw_in`  in  NUM_REGS*DATA_WIDTH  RO: value read; W1C/RC: per-bit set pulses.
- `reg_out`  out  NUM_REGS*DATA_WIDTH  current storage of every register; W1P reads 0.
- `pulse_out`  out  NUM_REGS*DATA_WIDTH  W1P pulses; 0 for other types.
- `irq`  out  1  OR of all W1C and RC storage bits.

## Operation
- write_act = chip_select & write_en & ~read_en; read_act = chip_select & read_en & ~write_en.
- Access error cases:
  - both enables set with chip_select: nothing changes; error response.
  - address misaligned (low log2(DATA_WIDTH/8) bits nonzero) or index ≥ NUM_REGS: error response.
- Error response: a write or read error sets resp_err and data_valid for one cycle next edge, with read_data = 0.
- Writes apply per byte where write_strb is set:
  - RW: store byte.
  - RO: ignored, no error.
  - W1P: pulse_out bits = write_data & byte mask for exactly one cycle.
  - W1C: clear bits written 1.
  - RC: ignored.
- W1C/RC set: any hw_in bit high sets the storage bit every cycle.
- Set priority: a hw set in the same cycle as a W1C clear or RC read-clear wins; the bit stays 1.
- Reads capture at the edge:
  - RW/W1C/RC: storage.
  - RO: hw_in slice.
  - W1P: 0.
- RC read: a valid read clears the whole register at the same edge it is captured (except bits set that cycle).
- Error accesses never modify storage.

## Timing
- Reset values: RW/W1C/RC storage = RESET_VALUES. read_data, data_valid, resp_err and pulse_out = 0; irq reflects reset storage.
- Write latency: storage and reg_out update at the edge sampling write_act. pulse_out is high the following cycle only.
- Read latency: 1 cycle; read_data and data_valid registered. read_data holds its value until the next read completes.
- data_valid is 0 for writes without error.
- Back-to-back accesses every cycle are allowed; no stall, no wait states.
- irq is combinational from storage: rises the cycle after a hw set, falls the cycle after the last bit clears.
- Reset asserted mid-access: all state returns to reset values immediately; the in-flight access is lost and no data_valid is produced.

## Test plan
- Reset with RESET_VALUES reg0 = 32'hA5A5_0000 -> reg_out[0] = 32'hA5A5_0000, read_data = 0, data_valid = 0, irq = 0.
- RW reg0: write 32'h1234_5678 with strb 4'b0101 over 32'hA5A5_0000 -> read next cycle returns 32'hA534_0078 with data_valid for 1 cycle.
- W1P reg2: write 32'h0000_0011 -> pulse_out[2] = 32'h11 for exactly one cycle, then 0; a read of reg2 returns 0.
- W1C reg3 with irq:
  - hw_in bit 4 pulsed -> irq high the next cycle.
  - Write 32'h10 in the same cycle as a new hw_in bit 4 pulse -> bit 4 stays 1.
  - A later write of 32'h10 alone clears it; irq falls.
- RC reg (type 4) with storage 32'h3 -> first read returns 32'h3; second read returns 0.
- Error cases:
  - addr 8'h02 -> resp_err and data_valid for 1 cycle.
  - Index NUM_REGS -> resp_err; no storage change.
  - Simultaneous write_en & read_en -> resp_err; no change.
